// File: rtl/line_process_sequencer.sv
// Line sequencer between the line buffers and a per-pixel kernel: streams LINE_WIDTH
// pixels out with X/Y coordinates, collects LINE_WIDTH results and pulses write-done.
module line_process_sequencer #(
    parameter int unsigned        LINE_WIDTH = 1600,
    parameter int unsigned        POS_BITS   = 12,
    parameter int unsigned        CHANNELS   = 4,
    parameter int unsigned        CH_BITS    = 8,
    parameter logic [CH_BITS-1:0] FILL       = 8'hFF
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             READ_LINE_DONE,
    input  logic [POS_BITS-1:0]              READ_POSY,
    input  logic                             BYPASS,
    input  logic                             ERR_CLR,
    output logic                             IN_DE,
    input  logic [CHANNELS*CH_BITS-1:0]      IN_DATA,
    output logic                             K_READY,
    output logic [POS_BITS-1:0]              K_POSX,
    output logic [POS_BITS-1:0]              K_POSY,
    input  logic                             K_RDEN,
    output logic [(CHANNELS-1)*CH_BITS-1:0]  K_IN_DATA,
    input  logic                             K_WREN,
    input  logic [(CHANNELS-1)*CH_BITS-1:0]  K_OUT_DATA,
    output logic                             OUT_DE,
    output logic [CHANNELS*CH_BITS-1:0]      OUT_DATA,
    output logic                             WRITE_LINE_DONE,
    output logic                             BUSY,
    output logic [1:0]                       ERR
);

    localparam int unsigned         DW    = CHANNELS * CH_BITS;
    localparam logic [POS_BITS-1:0] WIDTH = POS_BITS'(LINE_WIDTH);
    localparam logic [POS_BITS-1:0] LAST  = POS_BITS'(LINE_WIDTH - 1);
    localparam logic [POS_BITS-1:0] ONE   = POS_BITS'(1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q;
    logic [POS_BITS-1:0] posx_q;
    logic [POS_BITS-1:0] wposx_q;
    logic [POS_BITS-1:0] posy_q;
    logic [POS_BITS-1:0] pend_y_q;
    logic                pend_q;
    logic                mode_q;
    logic                byp_de_q;
    logic [1:0]          err_q;

    logic                accept;
    logic                take_pend;
    logic                take_pulse;
    logic                start;
    logic [POS_BITS-1:0] start_y;
    logic                pend_d;
    logic [POS_BITS-1:0] pend_y_d;
    logic                drop;
    logic                in_de;
    logic                k_wr_ok;
    logic                out_de;
    logic                last_write;
    logic                wr_err;

    // Channel 0 of the read data is replaced by FILL on the way out.
    logic unused_in_ch0;
    assign unused_in_ch0 = ^IN_DATA[CH_BITS-1:0];

    // A line may start from IDLE or straight out of DONE; a queued line has priority
    // over a pulse arriving in the same cycle, which then takes the freed queue slot.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        accept     = (state_q == S_IDLE) || (state_q == S_DONE);
        take_pend  = accept && pend_q;
        take_pulse = accept && !pend_q && READ_LINE_DONE;
        start      = take_pend || take_pulse;
        start_y    = take_pend ? pend_y_q : READ_POSY;
        pend_d     = pend_q && !take_pend;
        pend_y_d   = pend_y_q;
        drop       = 1'b0;
        if (READ_LINE_DONE && !take_pulse) begin
            if (!pend_d) begin
                pend_d   = 1'b1;
                pend_y_d = READ_POSY;
            end else begin
                drop = 1'b1;
            end
        end
    end

    assign in_de      = (state_q == S_READ) && (posx_q < WIDTH) && (mode_q || K_RDEN);
    assign k_wr_ok    = !mode_q && K_WREN && (state_q != S_IDLE) && (wposx_q < WIDTH);
    assign out_de     = mode_q ? byp_de_q : k_wr_ok;
    assign last_write = out_de && (wposx_q == LAST);
    assign wr_err     = K_WREN && ((state_q == S_IDLE) || (wposx_q >= WIDTH));

    assign IN_DE           = in_de;
    assign K_READY         = (state_q == S_READ) && !mode_q;
    assign K_POSX          = posx_q;
    assign K_POSY          = posy_q;
    assign K_IN_DATA       = IN_DATA[DW-1:CH_BITS];
    assign OUT_DE          = out_de;
    // Bypass data arrives one cycle after IN_DE, i.e. exactly when the delayed strobe is high.
    assign OUT_DATA        = out_de ? {(mode_q ? IN_DATA[DW-1:CH_BITS] : K_OUT_DATA), FILL} : '0;
    assign WRITE_LINE_DONE = (state_q == S_DONE);
    assign BUSY            = (state_q != S_IDLE);
    assign ERR             = err_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            posx_q   <= '0;
            wposx_q  <= '0;
            posy_q   <= '0;
            pend_y_q <= '0;
            pend_q   <= 1'b0;
            mode_q   <= 1'b0;
            byp_de_q <= 1'b0;
            err_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pend_q   <= pend_d;
            pend_y_q <= pend_y_d;
            err_q    <= (ERR_CLR ? 2'b00 : err_q) | {wr_err, drop};
            byp_de_q <= in_de && mode_q;
            if (in_de) begin
                posx_q <= posx_q + ONE;
            end
            if (out_de) begin
                wposx_q <= wposx_q + ONE;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        state_q <= S_READ;
                        posy_q  <= start_y;
                        mode_q  <= BYPASS;
                        posx_q  <= '0;
                        wposx_q <= '0;
                    end
                end
                S_READ: begin
                    if (in_de && (posx_q == LAST)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The final write may already have landed while still reading.
                    if (last_write || (wposx_q == WIDTH)) begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_process_sequencer.sv
// Directed/random bench for line_process_sequencer: an 8-pixel RGBX instance with a
// line-buffer and 3-cycle kernel model, plus a 1600-pixel 3x10-bit bypass instance.
module tb_line_process_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 8-pixel, 4x8-bit instance
    logic        a_rld, a_byp, a_clr, a_in_de, a_k_ready, a_k_rden, a_k_wren;
    logic        a_out_de, a_wld, a_busy;
    logic [11:0] a_posy_i, a_k_posx, a_k_posy;
    logic [31:0] a_in_data, a_out_data;
    logic [23:0] a_k_in, a_k_out;
    logic [1:0]  a_err;

    // 1600-pixel, 3x10-bit instance
    logic        b_rld, b_byp, b_clr, b_in_de, b_k_ready, b_k_rden, b_k_wren;
    logic        b_out_de, b_wld, b_busy;
    logic [11:0] b_posy_i, b_k_posx, b_k_posy;
    logic [29:0] b_in_data, b_out_data;
    logic [19:0] b_k_in, b_k_out;
    logic [1:0]  b_err;

    line_process_sequencer #(
        .LINE_WIDTH(8), .POS_BITS(12), .CHANNELS(4), .CH_BITS(8), .FILL(8'hFF)
    ) u_a (
        .CLK(clk), .RST_N(rst_n), .READ_LINE_DONE(a_rld), .READ_POSY(a_posy_i),
        .BYPASS(a_byp), .ERR_CLR(a_clr), .IN_DE(a_in_de), .IN_DATA(a_in_data),
        .K_READY(a_k_ready), .K_POSX(a_k_posx), .K_POSY(a_k_posy), .K_RDEN(a_k_rden),
        .K_IN_DATA(a_k_in), .K_WREN(a_k_wren), .K_OUT_DATA(a_k_out), .OUT_DE(a_out_de),
        .OUT_DATA(a_out_data), .WRITE_LINE_DONE(a_wld), .BUSY(a_busy), .ERR(a_err)
    );

    line_process_sequencer #(
        .LINE_WIDTH(1600), .POS_BITS(12), .CHANNELS(3), .CH_BITS(10), .FILL(10'h3FF)
    ) u_b (
        .CLK(clk), .RST_N(rst_n), .READ_LINE_DONE(b_rld), .READ_POSY(b_posy_i),
        .BYPASS(b_byp), .ERR_CLR(b_clr), .IN_DE(b_in_de), .IN_DATA(b_in_data),
        .K_READY(b_k_ready), .K_POSX(b_k_posx), .K_POSY(b_k_posy), .K_RDEN(b_k_rden),
        .K_IN_DATA(b_k_in), .K_WREN(b_k_wren), .K_OUT_DATA(b_k_out), .OUT_DE(b_out_de),
        .OUT_DATA(b_out_data), .WRITE_LINE_DONE(b_wld), .BUSY(b_busy), .ERR(b_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [23:0] data;
    } kw_t;

    // Reference world: line-buffer contents, kernel model, observation logs
    logic [31:0] a_pix [8];
    bit          kern_on = 1'b0;
    bit          a_extra = 1'b0;
    bit          a_prev_in_de = 1'b0;
    logic [11:0] a_prev_posx = '0;
    bit          a_kcap_pend = 1'b0;
    int          a_kcap = 0;
    kw_t         kq [$];
    int          a_in_cyc [$];
    int          a_posx_seen [$];
    logic [31:0] a_wr [$];
    int          a_wr_cyc [$];
    int          a_done_cyc [$];
    int          a_done_posy [$];
    int          a_done_wrn [$];
    bit          a_busy_prev = 1'b0;
    int          a_busy_fall = -1;

    bit          b_prev_in_de = 1'b0;
    logic [11:0] b_prev_posx = '0;
    int          b_wr_n = 0;
    int          b_bad = 0;
    int          b_done_n = 0;
    int          b_done_cyc = -1;

    function automatic logic [23:0] kfun(input logic [23:0] x);
        return x ^ 24'h5A3C96;
    endfunction

    function automatic logic [29:0] pixb(input int i);
        return 30'(32'(i) * 32'h9E37_79B1);
    endfunction

    function automatic int geti(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction

    function automatic logic [31:0] getw(input logic [31:0] q [$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive models at edge+1, observe at edge+2, then advance to next edge+1.
    task automatic cycle();
        kw_t         e;
        logic [29:0] pb;
        a_in_data = a_prev_in_de ? a_pix[a_prev_posx[2:0]] : $urandom;
        b_in_data = b_prev_in_de ? pixb(int'(b_prev_posx)) : 30'($urandom);
        a_k_rden  = kern_on ? ($urandom_range(0, 2) != 0) : 1'($urandom);
        a_k_wren  = 1'b0;
        a_k_out   = 24'($urandom);
        if (kq.size() > 0 && kq[0].due == cyc) begin
            a_k_wren = 1'b1;
            a_k_out  = kq[0].data;
            void'(kq.pop_front());
        end
        #1;
        if (a_kcap_pend) begin
            a_kcap++;
            e.due  = cyc + 2;
            e.data = kfun(a_k_in);
            kq.push_back(e);
            if (a_extra && a_kcap == 8) begin
                e.due  = cyc + 3;
                e.data = 24'($urandom);
                kq.push_back(e);
            end
        end
        a_kcap_pend = kern_on && a_in_de;
        if (a_in_de) begin
            a_in_cyc.push_back(cyc);
            a_posx_seen.push_back(int'(a_k_posx));
        end
        if (a_out_de) begin
            a_wr.push_back(a_out_data);
            a_wr_cyc.push_back(cyc);
        end
        if (a_wld) begin
            a_done_cyc.push_back(cyc);
            a_done_posy.push_back(int'(a_k_posy));
            a_done_wrn.push_back(a_wr.size());
        end
        if (a_busy_prev && !a_busy) a_busy_fall = cyc;
        a_busy_prev  = a_busy;
        a_prev_in_de = a_in_de;
        a_prev_posx  = a_k_posx;

        if (b_out_de) begin
            pb = pixb(b_wr_n);
            if (b_out_data !== {pb[29:10], 10'h3FF}) b_bad++;
            b_wr_n++;
        end
        if (b_wld) begin
            b_done_n++;
            b_done_cyc = cyc;
        end
        b_prev_in_de = b_in_de;
        b_prev_posx  = b_k_posx;

        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_mon();
        a_in_cyc.delete();
        a_posx_seen.delete();
        a_wr.delete();
        a_wr_cyc.delete();
        a_done_cyc.delete();
        a_done_posy.delete();
        a_done_wrn.delete();
        kq.delete();
        a_kcap      = 0;
        a_kcap_pend = 1'b0;
        a_busy_fall = -1;
    endtask

    task automatic pulse_a(input logic [11:0] y, input logic byp);
        a_rld    = 1'b1;
        a_posy_i = y;
        a_byp    = byp;
        cycle();
        a_rld    = 1'b0;
        a_posy_i = 12'($urandom);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (a_busy_fall < 0 && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, 64'(a_busy_fall >= 0), 64'd1);
    endtask

    task automatic check_kernel_line(input string tag, input int y);
        chk({tag, "_writes"}, a_wr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_data%0d", tag, i), getw(a_wr, i), {kfun(a_pix[i][31:8]), 8'hFF});
            chk($sformatf("%s_posx%0d", tag, i), geti(a_posx_seen, i), i);
        end
        chk({tag, "_done_n"}, a_done_cyc.size(), 1);
        chk({tag, "_done_after_last"}, geti(a_done_cyc, 0) - geti(a_wr_cyc, 7), 1);
        chk({tag, "_done_wrn"}, geti(a_done_wrn, 0), 8);
        chk({tag, "_posy"}, geti(a_done_posy, 0), y);
    endtask

    initial begin
        int t;
        int y;
        int k;
        rst_n = 1'b1;
        a_rld = 1'b0; a_byp = 1'b0; a_clr = 1'b0; a_posy_i = '0;
        a_k_rden = 1'b0; a_k_wren = 1'b0; a_k_out = '0; a_in_data = '0;
        b_rld = 1'b0; b_byp = 1'b0; b_clr = 1'b0; b_posy_i = '0;
        b_k_rden = 1'b0; b_k_wren = 1'b0; b_k_out = '0; b_in_data = '0;
        for (int i = 0; i < 8; i++) a_pix[i] = 32'(i) * 32'h0101_0100;
        #1;
        rst_n = 1'b0;
        repeat (3) cycle();
        chk("reset_outputs", {a_in_de, a_k_ready, a_k_posx, a_k_posy, a_out_de, a_out_data,
                              a_wld, a_busy, a_err}, '0);
        rst_n = 1'b1;
        cycle();

        // Bypass line, Y=5, pixel i = i*0x01010100
        clear_mon();
        kern_on = 1'b0;
        t = cyc;
        pulse_a(12'd5, 1'b1);
        a_byp = 1'b0;
        wait_idle("byp_timeout", 60);
        chk("byp_writes", a_wr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("byp_data%0d", i), getw(a_wr, i), {a_pix[i][31:8], 8'hFF});
            chk($sformatf("byp_posx%0d", i), geti(a_posx_seen, i), i);
        end
        chk("byp_in_n", a_in_cyc.size(), 8);
        chk("byp_in_first", geti(a_in_cyc, 0) - t, 1);
        chk("byp_out_first", geti(a_wr_cyc, 0) - t, 2);
        chk("byp_out_last", geti(a_wr_cyc, 7) - t, 9);
        chk("byp_done_n", a_done_cyc.size(), 1);
        chk("byp_done_t", geti(a_done_cyc, 0) - t, 10);
        chk("byp_busy_fall", a_busy_fall - t, 11);
        chk("byp_posy", geti(a_done_posy, 0), 5);
        chk("byp_err", a_err, 2'b00);

        // Kernel line with random read gaps and a 3-cycle kernel
        clear_mon();
        for (int i = 0; i < 8; i++) a_pix[i] = $urandom;
        kern_on = 1'b1;
        y = $urandom_range(1, 4000);
        pulse_a(12'(y), 1'b0);
        wait_idle("kern_timeout", 300);
        check_kernel_line("kern", y);
        chk("kern_err", a_err, 2'b00);

        // Requests during a busy line: Y=6 queued, Y=7 dropped
        clear_mon();
        kern_on = 1'b0;
        for (int i = 0; i < 8; i++) a_pix[i] = 32'(i) * 32'h0101_0100;
        pulse_a(12'd4, 1'b1);
        cycle();
        cycle();
        pulse_a(12'd6, 1'b1);
        cycle();
        cycle();
        pulse_a(12'd7, 1'b1);
        wait_idle("queue_timeout", 100);
        a_byp = 1'b0;
        chk("queue_done_n", a_done_cyc.size(), 2);
        chk("queue_posy0", geti(a_done_posy, 0), 4);
        chk("queue_posy1", geti(a_done_posy, 1), 6);
        chk("queue_writes", a_wr.size(), 16);
        chk("queue_restart", geti(a_in_cyc, 8) - geti(a_done_cyc, 0), 1);
        chk("queue_line2_len", geti(a_done_cyc, 1) - geti(a_done_cyc, 0), 10);
        for (int i = 0; i < 16; i++)
            chk($sformatf("queue_data%0d", i), getw(a_wr, i), {a_pix[i % 8][31:8], 8'hFF});
        chk("queue_err_drop", a_err, 2'b01);
        a_clr = 1'b1;
        cycle();
        a_clr = 1'b0;
        chk("queue_err_clr", a_err, 2'b00);

        // Kernel sends a 9th result after the line is complete
        clear_mon();
        for (int i = 0; i < 8; i++) a_pix[i] = $urandom;
        kern_on = 1'b1;
        a_extra = 1'b1;
        y = $urandom_range(1, 4000);
        pulse_a(12'(y), 1'b0);
        wait_idle("extra_timeout", 300);
        a_extra = 1'b0;
        check_kernel_line("extra", y);
        chk("extra_busy_fall", a_busy_fall - geti(a_done_cyc, 0), 1);
        chk("extra_err", a_err, 2'b10);
        a_clr = 1'b1;
        cycle();
        a_clr = 1'b0;
        chk("extra_err_clr", a_err, 2'b00);

        // Reset in the middle of a bypass line
        clear_mon();
        kern_on = 1'b0;
        pulse_a(12'd9, 1'b1);
        a_byp = 1'b0;
        k = 0;
        while (!(a_posx_seen.size() > 0 && a_posx_seen[$] == 4) && k < 20) begin
            cycle();
            k++;
        end
        chk("rst_reached_px4", k < 20, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {a_in_de, a_k_ready, a_k_posx, a_k_posy, a_out_de, a_out_data,
                                a_wld, a_busy, a_err}, '0);
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_no_done", a_done_cyc.size(), 0);
        clear_mon();
        for (int i = 0; i < 8; i++) a_pix[i] = $urandom;
        kern_on = 1'b1;
        y = $urandom_range(1, 4000);
        pulse_a(12'(y), 1'b0);
        wait_idle("post_rst_timeout", 300);
        check_kernel_line("post_rst", y);
        kern_on = 1'b0;

        // Wide bypass line on the 1600-pixel, 3x10-bit instance
        t = cyc;
        b_rld    = 1'b1;
        b_posy_i = 12'd321;
        b_byp    = 1'b1;
        cycle();
        b_rld = 1'b0;
        b_byp = 1'b0;
        k = 0;
        while (b_done_n == 0 && k < 1700) begin
            cycle();
            k++;
        end
        repeat (3) cycle();
        chk("wide_writes", b_wr_n, 1600);
        chk("wide_bad_data", b_bad, 0);
        chk("wide_done_n", b_done_n, 1);
        chk("wide_done_t", b_done_cyc - t, 1602);
        chk("wide_posy", b_k_posy, 12'd321);
        chk("wide_idle", b_busy, 1'b0);
        chk("wide_err", b_err, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
